// File: rtl/sfm_streamer_tail_filter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfm_streamer_tail_filter_pkg                                             |
// | Shared types and constants for the softmax streamer load-side tail      |
// | filter: FSM state encoding, streamer control struct, BF16 pad value and |
// | the leftover-byte helper that the store strobe generator also uses.     |
// | Ports: none (package).                                                  |
// | Revision: 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package sfm_streamer_tail_filter_pkg;

  // Default stream width for the streamer datapath.
  localparam int unsigned DATA_W = 128;

  // BF16 negative infinity; used as the pad value so that a max-reduction
  // over a padded tail lane is unaffected.
  localparam logic [15:0] SFM_BF16_NEG_INF = 16'hFF80;

  // Byte pad value for the default (zero-pad) build.
  localparam logic [7:0] SFM_PAD_ZERO = 8'h00;

  typedef enum logic [1:0] {
    TF_IDLE   = 2'd0,
    TF_STREAM = 2'd1,
    TF_DRAIN  = 2'd2,
    TF_DONE   = 2'd3
  } sfm_tail_state_t;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
  } hci_streamer_addressgen_ctrl_t;

  typedef struct packed {
    hci_streamer_addressgen_ctrl_t addressgen_ctrl;
  } hci_streamer_ctrl_t;

  // Number of valid bytes in the final beat (0 means the beat is full).
  // The low bits of (stride - 1) only depend on the low bits of stride, so
  // computing at full width and masking to lw bits is equivalent to working
  // on the truncated operands modulo 2^lw.
  function automatic logic [31:0] sfm_tail_leftover(
    input logic [31:0] len,
    input logic [31:0] stride,
    input int unsigned lw
  );
    logic [31:0] lane_mask;
    lane_mask = (32'd1 << lw) - 32'd1;
    return (len & (stride - 32'd1)) & lane_mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfm_streamer_tail_filter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfm_streamer_tail_filter_if                                              |
// | Valid/ready byte-strobed stream (hwpe_stream style).                     |
// | Signals: valid, ready, data[DW-1:0], strb[DW/8-1:0].                     |
// | Modports: master (drives valid/data/strb), slave (drives ready).         |
// | Revision: 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface sfm_streamer_tail_filter_if #(
  parameter int unsigned DW = sfm_streamer_tail_filter_pkg::DATA_W
) ();

  logic            valid;
  logic            ready;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] strb;

  modport master (
    output valid,
    output data,
    output strb,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  strb,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/sfm_tail_mask_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfm_tail_mask_gen                                                        |
// | Combinational tail mask: builds the byte-valid mask of a beat from the   |
// | leftover count and the final-beat flag, and pads the invalid bytes.      |
// | Ports:                                                                   |
// |   lftovr   in  LW   valid bytes in the final beat (0 = full beat)       |
// |   is_final in  1    beat is the last of the transfer                    |
// |   data_in  in  DW   raw beat data                                       |
// |   strb     out NB   byte mask (1 = byte carries real data)              |
// |   data_out out DW   data with invalid bytes replaced by the pad value   |
// | Build option: SFM_TAIL_PAD_NEG_INF_EN pads whole 16-bit lanes with BF16 |
// |   -inf instead of zero bytes.                                           |
// | Revision: 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sfm_tail_mask_gen
  import sfm_streamer_tail_filter_pkg::*;
#(
  parameter  int unsigned DW = DATA_W,
  localparam int unsigned NB = DW / 8,
  localparam int unsigned LW = $clog2(NB)
) (
  input  logic [LW-1:0] lftovr,
  input  logic          is_final,
  input  logic [DW-1:0] data_in,
  output logic [NB-1:0] strb,
  output logic [DW-1:0] data_out
);

  logic [NB-1:0] byte_mask;
  logic          full_beat;

  // Non-final beats and final beats with no leftover are passed whole.
  assign full_beat = !is_final || (lftovr == '0);

  for (genvar i = 0; i < NB; i++) begin : g_byte_mask
    assign byte_mask[i] = full_beat || (lftovr > LW'(i));
  end

  assign strb = byte_mask;

`ifdef SFM_TAIL_PAD_NEG_INF_EN
  // A lane survives only if its high byte is valid, so an odd leftover
  // drops the half-filled lane entirely rather than mixing bytes.
  for (genvar j = 0; j < NB / 2; j++) begin : g_lane_pad
    assign data_out[16*j +: 16] = byte_mask[2*j+1] ? data_in[16*j +: 16]
                                                   : SFM_BF16_NEG_INF;
  end
`else
  for (genvar i = 0; i < NB; i++) begin : g_byte_pad
    assign data_out[8*i +: 8] = byte_mask[i] ? data_in[8*i +: 8] : SFM_PAD_ZERO;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/sfm_streamer_tail_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfm_streamer_tail_filter                                                 |
// | Load-side tail filter for the softmax streamer. Counts accepted beats    |
// | of a load transfer, pads the bytes beyond the vector length on the final |
// | beat, and presents the result through a registered one-deep slice.       |
// | Ports:                                                                   |
// |   clk_i          in     clock                                          |
// |   rst_ni         in     asynchronous active-low reset                  |
// |   clear_i        in     synchronous clear (drops slice, back to idle)  |
// |   start_i        in     pulse; latches config and starts a transfer    |
// |   stream_ctrl_i  in     d0_len / d0_stride / tot_len                   |
// |   stream_i       slave  raw load beats from the HCI source             |
// |   stream_o       master filtered beats to the datapath                 |
// |   last_o         out    slice holds the final beat                     |
// |   done_o         out    pulse after the final beat leaves stream_o     |
// |   busy_o         out    not idle                                       |
// | Build option: SFM_TAIL_PAD_NEG_INF_EN (BF16 -inf lane padding, see      |
// |   sfm_tail_mask_gen); zero-byte padding otherwise.                      |
// | Revision: 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sfm_streamer_tail_filter
  import sfm_streamer_tail_filter_pkg::*;
#(
  parameter int unsigned DW = DATA_W
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  hci_streamer_ctrl_t                stream_ctrl_i,
  sfm_streamer_tail_filter_if.slave         stream_i,
  sfm_streamer_tail_filter_if.master        stream_o,
  output logic                              last_o,
  output logic                              done_o,
  output logic                              busy_o
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned LW = $clog2(NB);

  sfm_tail_state_t state_q, state_d;

  logic [31:0]   count_q;
  logic [31:0]   tot_len_q;
  logic [LW-1:0] lftovr_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [NB-1:0] out_strb_q;
  logic          last_q;
  logic          done_q, done_d;

  logic          in_ready;
  logic          in_hs;
  logic          out_hs;
  logic          is_final;
  logic          start_ok;
  logic [31:0]   lftovr_full;
  logic [NB-1:0] mask_strb;
  logic [DW-1:0] mask_data;

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  // The slice accepts a new beat when empty or when it is being emptied in
  // the same cycle, which keeps full throughput without a skid buffer.
  assign in_ready = (state_q == TF_STREAM) && (!out_valid_q || stream_o.ready);
  assign in_hs    = stream_i.valid && in_ready;
  assign out_hs   = out_valid_q && stream_o.ready;

  // tot_len_q is at least 1 whenever the FSM is in STREAM.
  assign is_final = (count_q == tot_len_q - 32'd1);
  assign start_ok = (state_q == TF_IDLE) && start_i;

  assign lftovr_full = sfm_tail_leftover(stream_ctrl_i.addressgen_ctrl.d0_len,
                                         stream_ctrl_i.addressgen_ctrl.d0_stride,
                                         LW);

  // ---------------------------------------------------------------------
  // Tail masking
  // ---------------------------------------------------------------------
  sfm_tail_mask_gen #(
    .DW (DW)
  ) u_mask_gen (
    .lftovr   (lftovr_q),
    .is_final (is_final),
    .data_in  (stream_i.data),
    .strb     (mask_strb),
    .data_out (mask_data)
  );

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      TF_IDLE: begin
        if (start_i) begin
          state_d = (stream_ctrl_i.addressgen_ctrl.tot_len == 32'd0) ? TF_DONE : TF_STREAM;
        end
      end
      TF_STREAM: begin
        if (in_hs && is_final) begin
          state_d = TF_DRAIN;
        end
      end
      TF_DRAIN: begin
        // done_o is registered, so it rises the cycle after the final pop.
        if (out_hs) begin
          state_d = TF_IDLE;
          done_d  = 1'b1;
        end
      end
      TF_DONE: begin
        state_d = TF_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = TF_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM state, beat counter and latched configuration
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= TF_IDLE;
      done_q    <= 1'b0;
      count_q   <= 32'd0;
      tot_len_q <= 32'd0;
      lftovr_q  <= '0;
    end else if (clear_i) begin
      state_q   <= TF_IDLE;
      done_q    <= 1'b0;
      count_q   <= 32'd0;
      tot_len_q <= 32'd0;
      lftovr_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_ok) begin
        count_q   <= 32'd0;
        tot_len_q <= stream_ctrl_i.addressgen_ctrl.tot_len;
        lftovr_q  <= lftovr_full[LW-1:0];
      end else if (in_hs && !is_final) begin
        // Holding at tot_len-1 keeps the counter from wrapping.
        count_q <= count_q + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output slice
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      last_q      <= 1'b0;
    end else if (clear_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      last_q      <= 1'b0;
    end else if (in_hs) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mask_data;
      out_strb_q  <= mask_strb;
      last_q      <= is_final;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end
  end

  assign stream_i.ready = in_ready;
  assign stream_o.valid = out_valid_q;
  assign stream_o.data  = out_data_q;
  assign stream_o.strb  = out_strb_q;
  assign last_o         = last_q;
  assign done_o         = done_q;
  assign busy_o         = (state_q != TF_IDLE);

  // Input strobes are ignored; the mask is derived from the config alone.
  logic unused_inputs;
  assign unused_inputs = ^{stream_i.strb,
                           stream_ctrl_i.addressgen_ctrl.base_addr,
                           lftovr_full[31:LW]};

endmodule
`default_nettype wire

// File: tb/tb_sfm_streamer_tail_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sfm_streamer_tail_filter                                              |
// | Self-checking bench: randomized load transfers against a queue-based    |
// | reference model of the tail filter, plus directed literal cases.        |
// | Honors SFM_TAIL_PAD_NEG_INF_EN the same way as the design build.        |
// | Revision: 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sfm_streamer_tail_filter;
  import sfm_streamer_tail_filter_pkg::*;

  localparam int unsigned DW = 128;
  localparam int unsigned NB = DW / 8;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  logic clear  = 1'b0;
  logic start  = 1'b0;
  hci_streamer_ctrl_t ctrl;
  logic last, done, busy;

  sfm_streamer_tail_filter_if #(.DW(DW)) in_if  ();
  sfm_streamer_tail_filter_if #(.DW(DW)) out_if ();

  sfm_streamer_tail_filter #(.DW(DW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .clear_i       (clear),
    .start_i       (start),
    .stream_ctrl_i (ctrl),
    .stream_i      (in_if),
    .stream_o      (out_if),
    .last_o        (last),
    .done_o        (done),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] strb;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            m_tot    = 0;
  int            m_lft    = 0;
  int            m_in_cnt = 0;
  longint        cyc      = 0;
  longint        done_due = -1;
  int            done_seen = 0;
  logic [DW-1:0] last_pop_data = '0;
  logic [NB-1:0] last_pop_strb = '0;
  logic [DW-1:0] last_sent_data = '0;

  function automatic int model_lftovr(input int unsigned len, input int unsigned stride);
    return int'((len % NB) & (((stride % NB) + NB - 1) % NB));
  endfunction

  function automatic beat_t model_beat(input logic [DW-1:0] din, input int k);
    beat_t b;
    bit    fin;
    bit    ok;
    fin    = (k == m_tot - 1);
    b.last = fin;
    for (int i = 0; i < int'(NB); i++) begin
      ok        = !fin || (m_lft == 0) || (i < m_lft);
      b.strb[i] = ok;
`ifdef SFM_TAIL_PAD_NEG_INF_EN
      if (!fin || (m_lft == 0) || (2 * (i / 2) + 2 <= m_lft))
        b.data[8*i +: 8] = din[8*i +: 8];
      else
        b.data[8*i +: 8] = (i % 2 == 0) ? 8'h80 : 8'hFF;
`else
      b.data[8*i +: 8] = ok ? din[8*i +: 8] : 8'h00;
`endif
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------
  // Per-cycle compare process
  // ---------------------------------------------------------------------
  initial begin : compare
    beat_t         e;
    logic          prev_stall;
    logic          prev_clear;
    logic [DW-1:0] prev_data;
    logic [NB-1:0] prev_strb;
    logic          prev_last;
    prev_stall = 1'b0;
    prev_clear = 1'b0;
    prev_data  = '0;
    prev_strb  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_ni) begin
        chk("done_o_timing", done, (cyc == done_due));
        if (prev_stall && !prev_clear) begin
          chk("stall_valid", out_if.valid, 1'b1);
          chk("stall_data",  out_if.data,  prev_data);
          chk("stall_strb",  out_if.strb,  prev_strb);
          chk("stall_last",  last,         prev_last);
        end
        if (!out_if.valid) chk("last_without_valid", last, 1'b0);
        if (out_if.valid && out_if.ready) begin
          chk("beat_expected", (exp_q.size() > 0), 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", out_if.data, e.data);
            chk("out_strb", out_if.strb, e.strb);
            chk("out_last", last, e.last);
            last_pop_data = out_if.data;
            last_pop_strb = out_if.strb;
            if (e.last) done_due = cyc + 1;
          end
        end
        if (in_if.valid && in_if.ready) begin
          chk("input_within_len", (m_in_cnt < m_tot), 1'b1);
          if (m_in_cnt < m_tot) exp_q.push_back(model_beat(in_if.data, m_in_cnt));
          m_in_cnt++;
        end
        if (done) done_seen++;
        prev_stall = out_if.valid && !out_if.ready;
        prev_clear = clear;
        prev_data  = out_if.data;
        prev_strb  = out_if.strb;
        prev_last  = last;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  logic          use_fixed  = 1'b0;
  logic [DW-1:0] fixed_data = '0;

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_out_ready(input int mode);
    case (mode)
      0:       out_if.ready = 1'b1;
      1:       out_if.ready = ~out_if.ready;
      default: out_if.ready = ($urandom_range(0, 1) == 1);
    endcase
  endtask

  // Called just after a rising edge; runs one whole transfer.
  task automatic run_transfer(input int unsigned len, input int unsigned stride, input int tot,
                              input int mode, input int vprob, input bit spam);
    int budget;
    int sent;
    bit hs;
    ctrl.addressgen_ctrl.d0_len    = len;
    ctrl.addressgen_ctrl.d0_stride = stride;
    ctrl.addressgen_ctrl.tot_len   = tot;
    ctrl.addressgen_ctrl.base_addr = $urandom;
    m_tot     = tot;
    m_lft     = model_lftovr(len, stride);
    m_in_cnt  = 0;
    done_seen = 0;
    if (tot == 0) done_due = cyc + 3;
    in_if.valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sent   = 0;
    budget = 0;
    while (!(sent == tot && done_seen > 0) && budget < 400) begin
      if (sent < tot && !in_if.valid && $urandom_range(0, 99) < vprob) begin
        in_if.valid = 1'b1;
        in_if.data  = use_fixed ? fixed_data : rand_data();
        in_if.strb  = NB'($urandom);
      end
      set_out_ready(mode);
      @(negedge clk);
      hs = in_if.valid && in_if.ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) begin
        last_sent_data = in_if.data;
        sent++;
        in_if.valid = 1'b0;
      end
      if (spam && sent < tot && $urandom_range(0, 3) == 0) begin
        ctrl.addressgen_ctrl.tot_len = $urandom_range(0, 9);
        ctrl.addressgen_ctrl.d0_len  = $urandom;
        start = 1'b1;
      end
      budget++;
    end
    start = 1'b0;
    chk("transfer_completes", (done_seen > 0), 1'b1);
    chk("beats_accepted", m_in_cnt, tot);
    out_if.ready = 1'b1;
    @(negedge clk);
    chk("idle_after_done", busy, 1'b0);
    chk("idle_ready_low", in_if.ready, 1'b0);
    chk("model_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin : main
    logic [DW-1:0] pat;
    int            busy_exp[3];
    bit            hs;
    int            wait_cnt;

    ctrl         = '0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.strb   = '0;
    out_if.ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", out_if.valid, 1'b0);
    chk("rst_data",  out_if.data,  '0);
    chk("rst_strb",  out_if.strb,  '0);
    chk("rst_last",  last,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_ready", in_if.ready, 1'b0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // 128-bit, stride 16, len 40, three beats, no backpressure
    chk("model_lftovr_40", model_lftovr(40, 16), 8);
    run_transfer(40, 16, 3, 0, 100, 1'b0);
    chk("t1_tail_strb", last_pop_strb, 16'h00FF);
    chk("t1_tail_low",  last_pop_data[63:0], last_sent_data[63:0]);
`ifdef SFM_TAIL_PAD_NEG_INF_EN
    chk("t1_tail_pad",  last_pop_data[127:64], {4{16'hFF80}});
`else
    chk("t1_tail_pad",  last_pop_data[127:64], 64'h0);
`endif

    // Same transfer with the sink toggling ready every cycle
    out_if.ready = 1'b1;
    run_transfer(40, 16, 3, 1, 100, 1'b0);
    chk("t2_tail_strb", last_pop_strb, 16'h00FF);

    // Leftover zero: every beat full
    chk("model_lftovr_48", model_lftovr(48, 16), 0);
    run_transfer(48, 16, 3, 0, 100, 1'b0);
    chk("t3_tail_strb", last_pop_strb, 16'hFFFF);
    chk("t3_tail_data", last_pop_data, last_sent_data);

    // Zero-length transfer: no input accepted, done two cycles after start
    ctrl.addressgen_ctrl.tot_len = 0;
    m_tot       = 0;
    m_in_cnt    = 0;
    done_seen   = 0;
    done_due    = cyc + 3;
    in_if.valid = 1'b1;
    in_if.data  = rand_data();
    start       = 1'b1;
    busy_exp    = '{0, 1, 0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_ready_low", in_if.ready, 1'b0);
      chk("t4_busy", busy, busy_exp[k][0]);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_if.valid = 1'b0;
    chk("t4_done_seen", done_seen, 1);

    // Single beat, leftover 7, fixed byte pattern A0+i
    for (int i = 0; i < int'(NB); i++) pat[8*i +: 8] = 8'hA0 + 8'(i);
    fixed_data = pat;
    use_fixed  = 1'b1;
    run_transfer(7, 16, 1, 0, 100, 1'b0);
    use_fixed  = 1'b0;
    chk("t5_strb", last_pop_strb, 16'h007F);
`ifdef SFM_TAIL_PAD_NEG_INF_EN
    chk("t5_data", last_pop_data, 128'hFF80FF80FF80FF80FF80A5A4A3A2A1A0);
`else
    chk("t5_data", last_pop_data, 128'h000000000000000000A6A5A4A3A2A1A0);
`endif

    // Clear after one of three beats, with that beat stuck in the slice
    out_if.ready = 1'b0;
    ctrl.addressgen_ctrl.d0_len    = 40;
    ctrl.addressgen_ctrl.d0_stride = 16;
    ctrl.addressgen_ctrl.tot_len   = 3;
    m_tot    = 3;
    m_lft    = model_lftovr(40, 16);
    m_in_cnt = 0;
    start    = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    in_if.valid = 1'b1;
    in_if.data  = rand_data();
    hs       = 1'b0;
    wait_cnt = 0;
    while (!hs && wait_cnt < 20) begin
      @(negedge clk);
      hs = in_if.valid && in_if.ready;
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("t6_first_beat", hs, 1'b1);
    in_if.valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    m_in_cnt = 0;
    @(negedge clk);
    chk("t6_busy_cleared",  busy, 1'b0);
    chk("t6_valid_cleared", out_if.valid, 1'b0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    out_if.ready = 1'b1;
    run_transfer(40, 16, 3, 0, 100, 1'b0);
    chk("t6_restart_strb", last_pop_strb, 16'h00FF);

    // Randomized transfers with backpressure, bubbles and ignored starts
    for (int t = 0; t < 14; t++) begin
      run_transfer($urandom, $urandom, $urandom_range(0, 6),
                   $urandom_range(0, 2), $urandom_range(40, 100), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
